// File: rtl/spi_param_regs_pkg.sv
// Shared constants for the SPI parameter register block: address map, frame
// geometry, FSM states and power-up register values.
package spi_param_regs_pkg;

  localparam int CMD_LEN   = 8;
  localparam int DATA_LEN  = 32;
  localparam int FRAME_LEN = CMD_LEN + DATA_LEN;

  localparam logic [6:0] ADDR_FRE_START = 7'h00;
  localparam logic [6:0] ADDR_FRE_END   = 7'h01;
  localparam logic [6:0] ADDR_FRE_STEP  = 7'h02;
  localparam logic [6:0] ADDR_CYCLE     = 7'h03;
  localparam logic [6:0] ADDR_ID        = 7'h04;

  localparam logic [31:0] ID_VALUE = 32'hDD50_0001;

  localparam logic [31:0] DEF_FRE_START = 32'd34300;
  localparam logic [31:0] DEF_FRE_END   = 32'd343000;
  localparam logic [31:0] DEF_STEP      = 32'd3430;
  localparam logic [31:0] DEF_CYCLE     = 32'd4999999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } spi_state_e;

  // Only the four sweep parameters accept writes; the ID word is read-only.
  function automatic logic is_writable(input logic [6:0] a);
    return a <= ADDR_CYCLE;
  endfunction

endpackage

// File: rtl/spi_param_regs_if.sv
// SPI pins between the host MCU (master) and the parameter register block (slave).
interface spi_param_regs_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_sclk, output spi_cs_n, output spi_mosi, input spi_miso);
  modport slave  (input spi_sclk, input spi_cs_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_param_regs_sync.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall pulses
// derived from the synchronized level only.
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_param_regs.sv
// SPI mode-0 slave holding the sweep parameters: 40-bit frames of command
// byte plus 32-bit word, with ID readback and one-clk commit pulse.
module spi_param_regs
  import spi_param_regs_pkg::*;
#(
  parameter logic [31:0] RST_FRE_START = DEF_FRE_START,
  parameter logic [31:0] RST_FRE_END   = DEF_FRE_END,
  parameter logic [31:0] RST_STEP      = DEF_STEP,
  parameter logic [31:0] RST_CYCLE     = DEF_CYCLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_param_regs_if.slave      spi,
  output logic [31:0]          fre_start,
  output logic [31:0]          fre_end,
  output logic [31:0]          fre_step,
  output logic [31:0]          cycle,
  output logic                 cfg_update
);

  logic       w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
  logic       r_mosi_m, r_mosi_s;
  spi_state_e r_state;
  logic [4:0] r_bit_cnt;
  logic [7:0] r_cmd;
  logic [30:0] r_data;
  logic [31:0] r_rd_shift;
  logic       r_miso, r_cfg_update;
  logic [31:0] r_fre_start, r_fre_end, r_fre_step, r_cycle;
  logic [7:0] w_cmd_next;
  logic [31:0] w_data_next;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_async(spi.spi_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .i_async(spi.spi_cs_n), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );

  // MOSI has the same two-flop latency as the sclk edge pulses, so it is
  // aligned with the rise it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_m <= 1'b0;
      r_mosi_s <= 1'b0;
    end else begin
      r_mosi_m <= spi.spi_mosi;
      r_mosi_s <= r_mosi_m;
    end
  end

  assign w_cmd_next  = {r_cmd[6:0], r_mosi_s};
  assign w_data_next = {r_data, r_mosi_s};

  function automatic logic [31:0] read_word(input logic [6:0] a);
    case (a)
      ADDR_FRE_START: return r_fre_start;
      ADDR_FRE_END:   return r_fre_end;
      ADDR_FRE_STEP:  return r_fre_step;
      ADDR_CYCLE:     return r_cycle;
      ADDR_ID:        return ID_VALUE;
      default:        return 32'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_cmd        <= '0;
      r_data       <= '0;
      r_rd_shift   <= '0;
      r_miso       <= 1'b0;
      r_cfg_update <= 1'b0;
      r_fre_start  <= RST_FRE_START;
      r_fre_end    <= RST_FRE_END;
      r_fre_step   <= RST_STEP;
      r_cycle      <= RST_CYCLE;
    end else begin
      r_cfg_update <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= ST_IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_cs_fall) begin
              r_state   <= ST_CMD;
              r_bit_cnt <= '0;
            end
          end
          ST_CMD: begin
            if (w_sclk_rise) begin
              r_cmd <= w_cmd_next;
              if (r_bit_cnt == 5'(CMD_LEN - 1)) begin
                r_state    <= ST_DATA;
                r_bit_cnt  <= '0;
                // Snapshot now so a write later in this frame cannot disturb it.
                r_rd_shift <= read_word(w_cmd_next[6:0]);
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_DATA: begin
            if (w_sclk_fall && !r_cmd[7]) begin
              r_miso     <= r_rd_shift[31];
              r_rd_shift <= {r_rd_shift[30:0], 1'b0};
            end
            if (w_sclk_rise) begin
              r_data <= w_data_next[30:0];
              if (r_bit_cnt == 5'(DATA_LEN - 1)) begin
                r_state <= ST_DONE;
                r_miso  <= 1'b0;
                if (r_cmd[7] && is_writable(r_cmd[6:0])) begin
                  r_cfg_update <= 1'b1;
                  case (r_cmd[6:0])
                    ADDR_FRE_START: r_fre_start <= w_data_next;
                    ADDR_FRE_END:   r_fre_end   <= w_data_next;
                    ADDR_FRE_STEP:  r_fre_step  <= w_data_next;
                    default:        r_cycle     <= w_data_next;
                  endcase
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          default: ; // DONE: trailing bits ignored until cs_n rises
        endcase
      end
    end
  end

  assign fre_start    = r_fre_start;
  assign fre_end      = r_fre_end;
  assign fre_step     = r_fre_step;
  assign cycle        = r_cycle;
  assign cfg_update   = r_cfg_update;
  assign spi.spi_miso = r_miso;

endmodule

// File: tb/tb_spi_param_regs.sv
// Bench for spi_param_regs: 50 MHz clk, 2 MHz host SPI, register model with
// per-cycle comparison plus literal expectations per directed frame.
module tb_spi_param_regs;

  localparam int SCK_HALF = 250;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] fre_start, fre_end, fre_step, cycle;
  logic cfg_update;

  spi_param_regs_if bus ();

  spi_param_regs u_dut (
    .clk(clk), .rst_n(rst_n), .spi(bus.slave),
    .fre_start(fre_start), .fre_end(fre_end), .fre_step(fre_step),
    .cycle(cycle), .cfg_update(cfg_update)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int cs_hi_cnt = 0;
  logic [31:0] exp_reg [4];
  logic        pend_vld = 1'b0;
  logic [1:0]  pend_addr = 2'd0;
  logic [31:0] pend_val = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic model_reset();
    exp_reg[0] = 32'd34300;
    exp_reg[1] = 32'd343000;
    exp_reg[2] = 32'd3430;
    exp_reg[3] = 32'd4999999;
    pend_vld   = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [6:0] a);
    if (a < 7'd4) return exp_reg[a[1:0]];
    if (a == 7'h04) return 32'hDD50_0001;
    return 32'd0;
  endfunction

  // Register outputs must track the model every cycle; a commit pulse is only
  // legal while a completed host write is outstanding.
  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_update) begin
        pulses++;
        chk("cfg_update_expected", {31'd0, pend_vld}, 32'd1);
        if (pend_vld) begin
          exp_reg[pend_addr] = pend_val;
          pend_vld = 1'b0;
        end
      end
      chk("fre_start", fre_start, exp_reg[0]);
      chk("fre_end", fre_end, exp_reg[1]);
      chk("fre_step", fre_step, exp_reg[2]);
      chk("cycle", cycle, exp_reg[3]);
      cs_hi_cnt = bus.spi_cs_n ? cs_hi_cnt + 1 : 0;
      if (cs_hi_cnt >= 4) chk("miso_idle", {31'd0, bus.spi_miso}, 32'd0);
    end
  end

  // One host frame of nbits rising edges; bits past 40 are driven as 1s.
  // rst_at >= 0 pulses rst_n around that rising edge.
  task automatic frame(input logic [7:0] cmd, input logic [31:0] data, input int nbits,
                       input int rst_at, output logic [31:0] rd, output logic cmd_miso_bad);
    logic [39:0] word;
    word = {cmd, data};
    rd = 32'd0;
    cmd_miso_bad = 1'b0;
    bus.spi_cs_n = 1'b0;
    #SCK_HALF;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = (i < 40) ? word[39-i] : 1'b1;
      #SCK_HALF;
      if (i >= 8 && i < 40) rd = {rd[30:0], bus.spi_miso};
      else if (i < 8 && bus.spi_miso) cmd_miso_bad = 1'b1;
      bus.spi_sclk = 1'b1;
      if (i == 39 && rst_at < 0 && cmd[7] && cmd[6:0] < 7'd4) begin
        pend_vld  = 1'b1;
        pend_addr = cmd[1:0];
        pend_val  = data;
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        model_reset();
      end
      #SCK_HALF;
      bus.spi_sclk = 1'b0;
      if (i == rst_at) rst_n = 1'b1;
    end
    #SCK_HALF;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    #(8 * SCK_HALF);
    chk("commit_done", {31'd0, pend_vld}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic bad;
    int p0;
    bus.spi_sclk = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    model_reset();
    #103;
    chk("rst_fre_start", fre_start, 32'd34300);
    chk("rst_fre_end", fre_end, 32'd343000);
    chk("rst_fre_step", fre_step, 32'd3430);
    chk("rst_cycle", cycle, 32'd4999999);
    chk("rst_cfg_update", {31'd0, cfg_update}, 32'd0);
    chk("rst_miso", {31'd0, bus.spi_miso}, 32'd0);
    rst_n = 1'b1;
    #200;

    // Single write to fre_end
    p0 = pulses;
    frame(8'h81, 32'h0000_C350, 40, -1, rd, bad);
    chk("w81_fre_end", fre_end, 32'd50000);
    chk("w81_others", fre_start ^ fre_step ^ cycle, 32'd34300 ^ 32'd3430 ^ 32'd4999999);
    chk("w81_pulses", 32'(pulses - p0), 32'd1);

    // Reads: ID, unmapped, written register
    p0 = pulses;
    exp_rd = model_read(7'h04);
    frame(8'h04, 32'h0, 40, -1, rd, bad);
    chk("r04_model", rd, exp_rd);
    chk("r04_literal", rd, 32'hDD50_0001);
    chk("r04_cmd_miso", {31'd0, bad}, 32'd0);
    frame(8'h7F, 32'hFFFF_FFFF, 40, -1, rd, bad);
    chk("r7f_zero", rd, 32'd0);
    exp_rd = model_read(7'h01);
    frame(8'h01, 32'h0, 40, -1, rd, bad);
    chk("r01_model", rd, exp_rd);
    chk("r01_literal", rd, 32'd50000);
    chk("reads_no_pulse", 32'(pulses - p0), 32'd0);

    // Writes to read-only ID and to an unmapped address
    p0 = pulses;
    frame(8'h84, 32'h1234_5678, 40, -1, rd, bad);
    frame(8'hFF, 32'h1234_5678, 40, -1, rd, bad);
    frame(8'h04, 32'h0, 40, -1, rd, bad);
    chk("ro_id_intact", rd, 32'hDD50_0001);
    chk("ro_no_pulse", 32'(pulses - p0), 32'd0);

    // Aborted write after 20 data bits, then a full one
    p0 = pulses;
    frame(8'h82, 32'h1234_5678, 28, -1, rd, bad);
    chk("abort_fre_step", fre_step, 32'd3430);
    chk("abort_no_pulse", 32'(pulses - p0), 32'd0);
    frame(8'h82, 32'd777, 40, -1, rd, bad);
    chk("after_abort_fre_step", fre_step, 32'd777);
    chk("after_abort_pulse", 32'(pulses - p0), 32'd1);

    // Trailing sclk pulses after a complete write
    p0 = pulses;
    frame(8'h83, 32'd99, 56, -1, rd, bad);
    chk("trail_cycle", cycle, 32'd99);
    chk("trail_one_pulse", 32'(pulses - p0), 32'd1);

    // Reset in the middle of the following frame
    p0 = pulses;
    frame(8'h80, 32'd1000, 40, -1, rd, bad);
    chk("pre_rst_fre_start", fre_start, 32'd1000);
    frame(8'h80, 32'hAAAA_5555, 40, 15, rd, bad);
    chk("post_rst_fre_start", fre_start, 32'd34300);
    chk("post_rst_cycle", cycle, 32'd4999999);
    chk("rst_frame_pulses", 32'(pulses - p0), 32'd1);
    frame(8'h80, 32'd5, 40, -1, rd, bad);
    chk("recover_fre_start", fre_start, 32'd5);

    // Back-to-back writes with 4-sclk gaps
    p0 = pulses;
    frame(8'h80, 32'd11, 40, -1, rd, bad);
    frame(8'h81, 32'd22, 40, -1, rd, bad);
    frame(8'h82, 32'd33, 40, -1, rd, bad);
    frame(8'h83, 32'd44, 40, -1, rd, bad);
    chk("b2b_pulses", 32'(pulses - p0), 32'd4);
    chk("b2b_fre_start", fre_start, 32'd11);
    chk("b2b_fre_end", fre_end, 32'd22);
    chk("b2b_fre_step", fre_step, 32'd33);
    chk("b2b_cycle", cycle, 32'd44);
    frame(8'h03, 32'h0, 40, -1, rd, bad);
    chk("r03_literal", rd, 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
